pack_response: RTL



---
 rtl/pack_response_pkg.sv | 40 ++++
 rtl/pack_response_resp_latency_ctr.sv | 31 +++
 rtl/pack_response.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pack_response_pkg.sv
// Shared definitions for the SPI-to-RAM command unpacker and response packer:
// command/status codes, 16-bit frame field positions and the framer state type.
package pack_response_pkg;

  localparam int FRAME_W    = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 8;
  localparam int ADDR_MSB   = 7;
  localparam int ADDR_LSB   = 4;
  localparam int CODE_MSB   = 3;
  localparam int CODE_LSB   = 0;
  // Status bit that carries frame parity when the parity build is selected
  localparam int PARITY_BIT = 3;

  localparam logic [3:0] CMD_WRITE  = 4'b0001;
  localparam logic [3:0] CMD_READ   = 4'b0010;
  localparam logic [3:0] STS_WR_ACK = 4'b1001;
  localparam logic [3:0] STS_RD_OK  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RAM,
    PRESENT
  } state_t;

  // Assemble a response frame from its three fields
  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [DATA_MSB-DATA_LSB:0] data,
    input logic [ADDR_MSB-ADDR_LSB:0] addr,
    input logic [CODE_MSB-CODE_LSB:0] code
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[DATA_MSB:DATA_LSB] = data;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[CODE_MSB:CODE_LSB] = code;
    return f;
  endfunction

endpackage

// File: rtl/pack_response_resp_latency_ctr.sv
// Down-counter that measures out the block-RAM read latency. Loaded with
// RD_LATENCY-1 on the read strobe; done is high while the count is zero,
// which is the cycle the RAM output is valid.
module resp_latency_ctr #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam logic [1:0] LOAD_VAL = 2'(RD_LATENCY - 1);

  logic [1:0] count_reg;

  // Load on a new read, then count down to zero and hold there
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 2'd0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (enable && (count_reg != 2'd0)) begin
      count_reg <= count_reg - 2'd1;
    end
  end

  assign done = (count_reg == 2'd0);

endmodule

// File: rtl/pack_response.sv
// Return-path framer: turns block-RAM read/write strobes into 16-bit response
// frames {data, address, status} for the SPI slave transmit shifter, handed
// over with a valid/ready handshake. A strobe that cannot be accepted sets a
// sticky overrun flag.
//
// Build option: define PACK_RESP_PARITY_EN to replace status bit 3 with even
// parity over frame bits [15:4] (bits [15:3] then hold an even number of ones).
module pack_response
  import pack_response_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write,
  input  logic               read,
  input  logic [3:0]         address,
  input  logic [7:0]         ram_dout,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [FRAME_W-1:0] tx_data,
  output logic               overrun
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("pack_response: RD_LATENCY must be in 1..3");
    end
  endgenerate

  state_t             state_reg;
  logic               tx_valid_reg;
  logic [FRAME_W-1:0] tx_data_reg;
  logic               overrun_reg;
  logic [3:0]         addr_latch_reg;

  logic accept;
  logic ctr_done;

  // Finalise the status field: optionally fold frame parity into bit 3
  function automatic logic [FRAME_W-1:0] seal(input logic [FRAME_W-1:0] f);
    logic [FRAME_W-1:0] r;
    r = f;
`ifdef PACK_RESP_PARITY_EN
    r[PARITY_BIT] = ^f[DATA_MSB:ADDR_LSB];
`endif
    return r;
  endfunction

  // A new strobe can be taken when idle, or in the handshake cycle of a
  // presented frame so that back-to-back responses need no bubble.
  assign accept = (state_reg == IDLE) ||
                  ((state_reg == PRESENT) && tx_valid_reg && tx_ready);

  resp_latency_ctr #(
    .RD_LATENCY(RD_LATENCY)
  ) u_latency_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && read),
    .enable (state_reg == WAIT_RAM),
    .done   (ctr_done)
  );

  // Framer FSM with registered frame, valid and overrun outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      tx_valid_reg   <= 1'b0;
      tx_data_reg    <= '0;
      overrun_reg    <= 1'b0;
      addr_latch_reg <= 4'h0;
    end else if (accept) begin
      if (read) begin
        // Read wins over a simultaneous write; the write is lost
        addr_latch_reg <= address;
        tx_valid_reg   <= 1'b0;
        state_reg      <= WAIT_RAM;
        if (write) begin
          overrun_reg <= 1'b1;
        end
      end else if (write) begin
        tx_data_reg  <= seal(make_frame(8'h00, address, STS_WR_ACK));
        tx_valid_reg <= 1'b1;
        state_reg    <= PRESENT;
      end else begin
        // tx_data keeps its last value; only valid drops
        tx_valid_reg <= 1'b0;
        state_reg    <= IDLE;
      end
    end else begin
      case (state_reg)
        WAIT_RAM: begin
          if (read || write) begin
            overrun_reg <= 1'b1;
          end
          if (ctr_done) begin
            tx_data_reg  <= seal(make_frame(ram_dout, addr_latch_reg, STS_RD_OK));
            tx_valid_reg <= 1'b1;
            state_reg    <= PRESENT;
          end
        end
        PRESENT: begin
          // Frame held stable until the shifter takes it
          if (read || write) begin
            overrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign overrun  = overrun_reg;

endmodule
